// File: rtl/dbg_loader_pkg.sv
// Shared constants for the instruction-memory debug loader: opcodes, echo codes, FSM encoding.
// ST_ACK exists only when DBG_LOADER_ECHO_EN is defined.
package dbg_loader_pkg;

  localparam logic [7:0] OP_ADDR  = 8'h41;
  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] ACK_CODE = 8'h06;
  localparam logic [7:0] NAK_CODE = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARG,
    ST_SETA,
    ST_WR,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_SEND
`ifdef DBG_LOADER_ECHO_EN
    , ST_ACK
`endif
  } state_e;

endpackage

// File: rtl/imem_debug_loader_if.sv
// Byte-stream (rx/tx) and instruction-memory debug port bundle for the loader.
// master = loader side, slave = UART/RAM side.
interface imem_debug_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] A2;
  logic [31:0] WD2;
  logic [3:0]  WE2;
  logic [31:0] RD2;

  modport master (
    input  rx_data, rx_valid, tx_ready, RD2,
    output rx_ready, tx_data, tx_valid, A2, WD2, WE2
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, RD2,
    input  rx_ready, tx_data, tx_valid, A2, WD2, WE2
  );
endinterface

// File: rtl/dbg_word_shifter.sv
// 32-bit word shifter: bytes shift in little-endian at the top, parallel load,
// bytes shift out LSB first from the bottom. Load wins over either shift.
module dbg_word_shifter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        shift_in,
  input  logic [7:0]  din,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic        shift_out,
  output logic [31:0] word,
  output logic [7:0]  dout
);

  logic [31:0] word_q, word_d;

  always_comb begin
    word_d = word_q;
    if (load)           word_d = load_data;
    else if (shift_in)  word_d = {din, word_q[31:8]};
    else if (shift_out) word_d = {8'h00, word_q[31:8]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) word_q <= '0;
    else        word_q <= word_d;
  end

  assign word = word_q;
  assign dout = word_q[7:0];

endmodule

// File: rtl/imem_debug_loader.sv
// Byte-command loader for the instruction-memory debug port ('A' set pointer, 'W' write, 'R' read).
// Optional DBG_LOADER_ECHO_EN: ACK/NAK byte returned after 'A'/'W' and after errors.
module imem_debug_loader
  import dbg_loader_pkg::*;
#(
  parameter int DEPTH_WORDS    = 4096,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                rst_n,
  imem_debug_loader_if.master bus,
  output logic                cpu_hold,
  output logic                cmd_err
);

  localparam int PTR_W = $clog2(DEPTH_WORDS);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

`ifdef DBG_LOADER_ECHO_EN
  localparam state_e ST_DONE = ST_ACK;
`else
  localparam state_e ST_DONE = ST_IDLE;
`endif

  state_e           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [31:0]      a2_q, a2_d;
  logic [31:0]      wd_q, wd_d;
  logic [3:0]       we_q, we_d;
  logic             err_q, err_d;
  logic             is_wr_q, is_wr_d;
`ifdef DBG_LOADER_ECHO_EN
  logic [7:0]       resp_q, resp_d;
`endif

  logic        sh_in, sh_load, sh_out;
  logic [31:0] sh_word;
  logic [7:0]  sh_byte;
  logic        rx_fire, tx_fire;
  logic        unused_arg;

  // One shifter serves both the argument assembly and the read-back serializer.
  dbg_word_shifter u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .shift_in  (sh_in),
    .din       (bus.rx_data),
    .load      (sh_load),
    .load_data (bus.RD2),
    .shift_out (sh_out),
    .word      (sh_word),
    .dout      (sh_byte)
  );

  assign bus.rx_ready = (state_q == ST_IDLE) || (state_q == ST_ARG);
`ifdef DBG_LOADER_ECHO_EN
  assign bus.tx_valid = (state_q == ST_SEND) || (state_q == ST_ACK);
  assign bus.tx_data  = (state_q == ST_ACK) ? resp_q : sh_byte;
`else
  assign bus.tx_valid = (state_q == ST_SEND);
  assign bus.tx_data  = sh_byte;
`endif
  assign bus.A2   = a2_q;
  assign bus.WD2  = wd_q;
  assign bus.WE2  = we_q;
  assign cpu_hold = (state_q != ST_IDLE);
  assign cmd_err  = err_q;

  assign rx_fire    = bus.rx_valid && bus.rx_ready;
  assign tx_fire    = bus.tx_valid && bus.tx_ready;
  assign unused_arg = ^sh_word;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    a2_d    = a2_q;
    wd_d    = wd_q;
    we_d    = 4'h0;
    err_d   = 1'b0;
    is_wr_d = is_wr_q;
    sh_in   = 1'b0;
    sh_load = 1'b0;
    sh_out  = 1'b0;
`ifdef DBG_LOADER_ECHO_EN
    resp_d  = resp_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rx_fire) begin
          cnt_d = 2'd0;
          tmo_d = '0;
          case (bus.rx_data)
            OP_ADDR, OP_WRITE: begin
              is_wr_d = (bus.rx_data == OP_WRITE);
              state_d = ST_ARG;
            end
            OP_READ: begin
              a2_d    = 32'({ptr_q, 2'b00});
              state_d = ST_RD_ADDR;
            end
            default: begin
              err_d   = 1'b1;
              state_d = ST_DONE;
`ifdef DBG_LOADER_ECHO_EN
              resp_d  = NAK_CODE;
`endif
            end
          endcase
        end
      end
      ST_ARG: begin
        if (rx_fire) begin
          sh_in = 1'b1;
          cnt_d = cnt_q + 2'd1;
          tmo_d = '0;
          if (cnt_q == 2'd3) begin
            if (is_wr_q) begin
              // Assemble the final word from the byte being accepted this cycle.
              we_d    = 4'hF;
              wd_d    = {bus.rx_data, sh_word[31:8]};
              a2_d    = 32'({ptr_q, 2'b00});
              state_d = ST_WR;
            end else begin
              state_d = ST_SETA;
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
`ifdef DBG_LOADER_ECHO_EN
          resp_d  = NAK_CODE;
`endif
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_SETA: begin
        ptr_d   = sh_word[PTR_W+1:2];
        state_d = ST_DONE;
`ifdef DBG_LOADER_ECHO_EN
        resp_d  = ACK_CODE;
`endif
      end
      ST_WR: begin
        ptr_d   = ptr_q + PTR_W'(1);
        state_d = ST_DONE;
`ifdef DBG_LOADER_ECHO_EN
        resp_d  = ACK_CODE;
`endif
      end
      ST_RD_ADDR: state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        sh_load = 1'b1;
        cnt_d   = 2'd0;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (tx_fire) begin
          sh_out = 1'b1;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            ptr_d   = ptr_q + PTR_W'(1);
            state_d = ST_IDLE;
          end
        end
      end
`ifdef DBG_LOADER_ECHO_EN
      ST_ACK: if (tx_fire) state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= 2'd0;
      tmo_q   <= '0;
      a2_q    <= '0;
      wd_q    <= '0;
      we_q    <= 4'h0;
      err_q   <= 1'b0;
      is_wr_q <= 1'b0;
`ifdef DBG_LOADER_ECHO_EN
      resp_q  <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      a2_q    <= a2_d;
      wd_q    <= wd_d;
      we_q    <= we_d;
      err_q   <= err_d;
      is_wr_q <= is_wr_d;
`ifdef DBG_LOADER_ECHO_EN
      resp_q  <= resp_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_debug_loader.sv
// Randomized bench for imem_debug_loader against a word-array/pointer reference model.
// Honors DBG_LOADER_ECHO_EN for ACK/NAK expectations.
module tb_imem_debug_loader;

  localparam int DEPTH = 256;
  localparam int TMO   = 40;

  logic clk = 1'b0;
  logic rst_n;
  logic cpu_hold, cmd_err;

  imem_debug_loader_if bus();

  imem_debug_loader #(.DEPTH_WORDS(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.master),
    .cpu_hold (cpu_hold),
    .cmd_err  (cmd_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] seed    [DEPTH];
  logic [31:0] ram     [DEPTH];
  logic [31:0] mdl_mem [DEPTH];
  bit          seeded = 1'b0;
  int          mdl_ptr;

  logic [63:0] wr_q[$];
  logic [7:0]  tx_q[$];
  int          err_pulses = 0, err0 = 0;
  int          stable_bad = 0, rx_bad = 0, we_wide = 0;
  logic [31:0] a2_max = '0;
  int          tx_stall = 0;
  bit          prev_we = 1'b0;
  int          stall_cnt = 0;
  bit          pend = 1'b0;
  logic [7:0]  pend_data;

  // Synchronous RAM on the debug port, seeded once from the shared init image.
  always @(posedge clk) begin
    if (!seeded) begin
      ram    <= seed;
      seeded <= 1'b1;
    end else if (bus.WE2 == 4'hF) begin
      ram[(bus.A2 >> 2) % DEPTH] <= bus.WD2;
    end
    bus.RD2 <= ram[(bus.A2 >> 2) % DEPTH];
  end

  // Monitor and tx sink, both sampling on the falling edge.
  always @(negedge clk) begin
    if (bus.WE2 != 4'h0) begin
      wr_q.push_back({bus.A2, bus.WD2});
      if (bus.WE2 != 4'hF || prev_we) we_wide++;
    end
    prev_we = (bus.WE2 != 4'h0);
    if (cmd_err) err_pulses++;
    if (bus.A2 > a2_max) a2_max = bus.A2;
    if (bus.tx_valid) begin
      if (bus.rx_ready) rx_bad++;
      if (pend && bus.tx_data != pend_data) stable_bad++;
      if (stall_cnt < tx_stall) begin
        stall_cnt++;
        bus.tx_ready = 1'b0;
        pend = 1'b1;
        pend_data = bus.tx_data;
      end else begin
        bus.tx_ready = 1'b1;
        tx_q.push_back(bus.tx_data);
        stall_cnt = 0;
        pend = 1'b0;
      end
    end else begin
      bus.tx_ready = 1'($urandom & 1);
      stall_cnt = 0;
      pend = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("rx_accept_bound", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (cpu_hold && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk({tag, "_idle_bound"}, 64'd0, 64'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic start_op();
    wr_q.delete();
    tx_q.delete();
    err0 = err_pulses;
  endtask

  task automatic chk_echo(input string tag, input logic [7:0] code);
`ifdef DBG_LOADER_ECHO_EN
    logic [7:0] got;
    chk({tag, "_echo_n"}, 64'(tx_q.size()), 64'd1);
    got = (tx_q.size() > 0) ? tx_q[0] : 8'hxx;
    chk({tag, "_echo_code"}, 64'(got), 64'(code));
`else
    chk({tag, "_no_tx"}, 64'(tx_q.size()), 64'(code & 8'h00));
`endif
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      gap();
      send_byte(w[8*i +: 8]);
    end
  endtask

  task automatic do_addr(input logic [31:0] a);
    start_op();
    send_byte(8'h41);
    send_word(a);
    wait_idle("addr");
    mdl_ptr = int'((a >> 2) % DEPTH);
    chk("addr_no_write", 64'(wr_q.size()), 64'd0);
    chk("addr_no_err", 64'(err_pulses - err0), 64'd0);
    chk_echo("addr", 8'h06);
  endtask

  task automatic do_write(input logic [31:0] d);
    logic [63:0] got;
    start_op();
    send_byte(8'h57);
    send_word(d);
    wait_idle("write");
    got = (wr_q.size() > 0) ? wr_q[0] : 64'hx;
    chk("wr_count", 64'(wr_q.size()), 64'd1);
    chk("wr_addr_data", got, {32'(mdl_ptr * 4), d});
    chk("wr_no_err", 64'(err_pulses - err0), 64'd0);
    chk_echo("write", 8'h06);
    mdl_mem[mdl_ptr] = d;
    mdl_ptr = (mdl_ptr + 1) % DEPTH;
  endtask

  task automatic do_read(input int stall);
    logic [7:0] got;
    tx_stall = stall;
    start_op();
    send_byte(8'h52);
    wait_idle("read");
    chk("rd_nbytes", 64'(tx_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
      chk($sformatf("rd_byte%0d", i), 64'(got), 64'(mdl_mem[mdl_ptr][8*i +: 8]));
    end
    chk("rd_a2", 64'(bus.A2), 64'(mdl_ptr * 4));
    chk("rd_no_write", 64'(wr_q.size()), 64'd0);
    mdl_ptr = (mdl_ptr + 1) % DEPTH;
    tx_stall = 0;
  endtask

  task automatic do_bad(input logic [7:0] b);
    start_op();
    send_byte(b);
    wait_idle("bad");
    chk("bad_err_pulse", 64'(err_pulses - err0), 64'd1);
    chk("bad_no_write", 64'(wr_q.size()), 64'd0);
    chk_echo("bad", 8'h15);
  endtask

  initial begin
    logic [7:0] b;
    for (int i = 0; i < DEPTH; i++) seed[i] = $urandom;
    seed[4] = 32'hDEADBEEF;
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = seed[i];
    mdl_ptr = 0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_a2", 64'(bus.A2), 64'd0);
    chk("rst_wd2", 64'(bus.WD2), 64'd0);
    chk("rst_we2", 64'(bus.WE2), 64'd0);
    chk("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
    chk("rst_tx_data", 64'(bus.tx_data), 64'd0);
    chk("rst_rx_ready", 64'(bus.rx_ready), 64'd1);
    chk("rst_cpu_hold", 64'(cpu_hold), 64'd0);
    chk("rst_cmd_err", 64'(cmd_err), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_write(32'h12345678);
    do_read(0);

    do_addr(32'h0000_0010);
    do_read(0);

    do_addr(32'((DEPTH - 1) * 4));
    do_write($urandom);
    do_write($urandom);

    // Argument timeout: two bytes then silence.
    start_op();
    send_byte(8'h57);
    send_byte(8'hAA);
    send_byte(8'hBB);
    repeat (TMO + 10) @(negedge clk);
    wait_idle("tmo");
    chk("tmo_err_pulse", 64'(err_pulses - err0), 64'd1);
    chk("tmo_no_write", 64'(wr_q.size()), 64'd0);
    chk("tmo_idle", 64'(cpu_hold), 64'd0);
    chk_echo("tmo", 8'h15);
    do_read(0);

    rx_bad = 0;
    stable_bad = 0;
    do_read(10);
    chk("stall_tx_stable", 64'(stable_bad), 64'd0);
    chk("stall_rx_blocked", 64'(rx_bad), 64'd0);

    do_bad(8'h99);

    // Reset in the middle of an argument phase.
    start_op();
    send_byte(8'h57);
    send_byte(8'h01);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_hold", 64'(cpu_hold), 64'd0);
    chk("midrst_rx_ready", 64'(bus.rx_ready), 64'd1);
    chk("midrst_we2", 64'(bus.WE2), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mdl_ptr = 0;
    do_read(0);

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 9))
        0: do_addr($urandom);
        1: do_addr(32'(($urandom_range(DEPTH - 3, DEPTH - 1)) * 4));
        2, 3, 4: do_write($urandom);
        5, 6, 7: do_read(int'($urandom_range(0, 3)));
        default: begin
          b = 8'($urandom);
          while (b == 8'h41 || b == 8'h57 || b == 8'h52) b = 8'($urandom);
          do_bad(b);
        end
      endcase
    end

    chk("a2_bound", 64'(a2_max <= 32'((DEPTH - 1) * 4)), 64'd1);
    chk("we_single_cycle", 64'(we_wide), 64'd0);
    chk("tx_stable_all", 64'(stable_bad), 64'd0);
    chk("rx_blocked_all", 64'(rx_bad), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
